// File: rtl/data_memory_pkg.sv
// Shared constants for the load/store data RAM: default geometry and WR_RD encoding.
package datamemory_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DEPTH_LOG2 = 10;

  localparam logic ACCESS_READ  = 1'b1;
  localparam logic ACCESS_WRITE = 1'b0;

endpackage

// File: rtl/data_memory_if.sv
// Load/store stage bus to the data RAM: chip select, direction, word address, data in/out.
interface data_memory_if
  import datamemory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  WR_RD;
  logic                  cs;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output WR_RD, output cs, output ADDR, output din, input dout);
  modport slave  (input WR_RD, input cs, input ADDR, input din, output dout);

endinterface

// File: rtl/data_memory_array.sv
// Plain word storage: synchronous write, combinational read, no reset.
// Contents start at all zeros.
module data_memory_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM with one-cycle registered read.
// Define DATAMEM_ASYNC_READ_EN for a combinational, zero-latency read path instead.
module data_memory
  import datamemory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input logic         clk,
  input logic         reset,
  data_memory_if.slave bus
);

  logic                  in_range;
  logic                  rd_sel;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_WIDTH-1:0] rd_data;

  // Upper address bits must be zero; nothing above the array aliases back in.
  assign in_range = (bus.ADDR >> DEPTH_LOG2) == '0;
  assign idx      = bus.ADDR[DEPTH_LOG2-1:0];
  assign rd_sel   = bus.cs && (bus.WR_RD == ACCESS_READ);
  assign wr_en    = bus.cs && (bus.WR_RD == ACCESS_WRITE) && in_range && !reset;

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (idx),
    .wdata_i (bus.din),
    .raddr_i (idx),
    .rdata_o (rd_data)
  );

`ifdef DATAMEM_ASYNC_READ_EN
  assign bus.dout = (rd_sel && in_range && !reset) ? rd_data : '0;
`else
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  always_comb begin
    dout_d = dout_q;
    if (rd_sel) dout_d = in_range ? rd_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory; follows DATAMEM_ASYNC_READ_EN to pick the read timing.
module tb_data_memory;
  import datamemory_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DL = DEF_DEPTH_LOG2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [DW-1:0] model_mem [0:(1<<DL)-1];
  logic [DW-1:0] model_dout;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (a >> DL) == '0;
  endfunction

  // One bus cycle: drive at negedge, push the expected dout, pop and compare when it is due.
  task automatic cycle(input string tag, input logic c, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    logic [DL-1:0] ix;
    ix = a[DL-1:0];
    @(negedge clk);
    bus.cs = c; bus.WR_RD = w; bus.ADDR = a; bus.din = d;
`ifdef DATAMEM_ASYNC_READ_EN
    exp_q.push_back((c && w == ACCESS_READ && addr_ok(a)) ? model_mem[ix] : '0);
    #1 check(tag, bus.dout, exp_q.pop_front());
    if (c && w == ACCESS_WRITE && addr_ok(a)) model_mem[ix] = d;
    @(posedge clk);
`else
    if (c && w == ACCESS_WRITE && addr_ok(a)) model_mem[ix] = d;
    if (c && w == ACCESS_READ) model_dout = addr_ok(a) ? model_mem[ix] : '0;
    exp_q.push_back(model_dout);
    @(posedge clk);
    #1 check(tag, bus.dout, exp_q.pop_front());
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] wvals [4];

  initial begin
    wvals = '{32'hABCDEFFF, 32'h12345678, 32'h98765432, 32'hAAAA5555};
    for (int i = 0; i < (1 << DL); i++) model_mem[i] = '0;
    model_dout = '0;
    bus.cs = 1'b0; bus.WR_RD = ACCESS_READ; bus.ADDR = '0; bus.din = '0;

    #1 check("reset_dout", bus.dout, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) cycle($sformatf("init_rd%0d", i), 1'b1, ACCESS_READ, AW'(i), '0);
    for (int i = 0; i < 4; i++) cycle($sformatf("wr_hold%0d", i), 1'b1, ACCESS_WRITE, AW'(i), wvals[i]);
    for (int i = 0; i < 4; i++) cycle($sformatf("rd%0d", i), 1'b1, ACCESS_READ, AW'(i), '0);

    // Mid-cycle async reset, with a write attempt on an edge while reset is held.
    #2 reset = 1'b1;
    #1 check("async_rst_dout", bus.dout, '0);
    @(negedge clk);
    bus.cs = 1'b1; bus.WR_RD = ACCESS_WRITE; bus.ADDR = AW'(3); bus.din = 32'h0;
    @(posedge clk);
    #1 check("rst_held_dout", bus.dout, '0);
    @(negedge clk);
    bus.cs = 1'b0;
    reset = 1'b0;
    model_dout = '0;
    cycle("rst_preserved", 1'b1, ACCESS_READ, AW'(3), '0);

    for (int i = 0; i < 3; i++) cycle($sformatf("cs0_%0d", i), 1'b0, ACCESS_WRITE, AW'(1), 32'hDEADBEEF);
    cycle("cs0_mem1", 1'b1, ACCESS_READ, AW'(1), '0);

    cycle("oor_wr", 1'b1, ACCESS_WRITE, AW'(32'h400), 32'h11111111);
    cycle("oor_rd", 1'b1, ACCESS_READ, AW'(32'h400), '0);
    cycle("no_alias0", 1'b1, ACCESS_READ, AW'(0), '0);
    cycle("top_wr", 1'b1, ACCESS_WRITE, AW'(32'h3FF), 32'hC0FFEE01);
    cycle("top_rd", 1'b1, ACCESS_READ, AW'(32'h3FF), '0);
    cycle("oor_max", 1'b1, ACCESS_READ, AW'(32'hFFFFFFFF), '0);
    cycle("wr_then_rd_w", 1'b1, ACCESS_WRITE, AW'(5), 32'h5A5A0F0F);
    cycle("wr_then_rd_r", 1'b1, ACCESS_READ, AW'(5), '0);
    cycle("idle_cs0", 1'b0, ACCESS_READ, AW'(5), '0);

    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      cycle($sformatf("rand%0d", i), 1'b1, ($urandom_range(0, 1) == 1) ? ACCESS_READ : ACCESS_WRITE,
            a, $urandom());
    end

    if (exp_q.size() != 0) check("scoreboard_drain", DW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Single-port, word-addressed synchronous data RAM for the MIPS CPU datapath, accessed by the load/store stage.
- One shared address bus, a direction select (WR_RD) and a chip select (cs).
- Writes commit on the rising clock edge.
- Reads return registered data with one-cycle latency.

Parameters:
DATA_WIDTH, 32, width of din/dout and of each memory word
ADDR_WIDTH, 32, width of the ADDR bus
DEPTH_LOG2, 10, log2 of word count (1024 words); ADDR[DEPTH_LOG2-1:0] is the word index

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
WR_RD  input  1  direction: 1 = read, 0 = write
cs  input  1  chip select; no access when 0
ADDR  input  ADDR_WIDTH  word address (not byte address; consecutive words are ADDR 0,1,2,...)
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  registered read data

Behaviour:
- Reset:
  - reset=1 forces dout to 0 immediately, asynchronously.
  - dout stays 0 while reset is held.
  - Memory array contents are not cleared by reset.
  - Array powers up / initialises to all zeros at time 0.
- Reset mid-operation: an access whose edge coincides with reset=1 is discarded; no write occurs.
- In range: ADDR[ADDR_WIDTH-1:DEPTH_LOG2] == 0.
- Write, at rising edge with cs=1, WR_RD=0 and address in range:
  - mem[ADDR[DEPTH_LOG2-1:0]] <= din.
  - dout holds its previous value.
- Read, at rising edge with cs=1, WR_RD=1:
  - dout <= mem[index] when in range; dout <= 0 when out of range.
  - Latency is 1 cycle: data is visible after the edge that samples the address.
- Out-of-range write: ignored, no aliasing.
- cs=0: no write; dout holds its last value.
- Write followed by read of the same address on the next edge returns the newly written data. No read-during-write case exists because the port is single-direction per cycle.
- Address wrap-around: none; addresses at or above 2**DEPTH_LOG2 are out of range, handled as above.
- No internal state machine; all behaviour is a function of the sampled cs/WR_RD/ADDR/din at each edge.

Optional Feature:
Macro DATAMEM_ASYNC_READ_EN.
- Defined:
  - dout is combinational: mem[index] when cs=1, WR_RD=1, in range and reset=0; otherwise 0.
  - Zero-latency read.
  - A write becomes visible on dout only when a read is later selected.
- Undefined: registered one-cycle read as specified above.
- Write behaviour is identical in both builds.

Decomposition:
- Package datamemory_pkg:
  - default DATA_WIDTH/ADDR_WIDTH/DEPTH_LOG2 constants
  - WR_RD encoding constants (ACCESS_READ = 1'b1, ACCESS_WRITE = 1'b0)
- Sub-module data_memory_array:
  - plain storage array with write enable, write index/data and read index
  - combinational read, no reset
- Top data_memory contains:
  - range decode
  - cs/WR_RD qualification
  - output register with async reset
  - the DATAMEM_ASYNC_READ_EN mux

Test Plan:
1. Assert reset=1 mid-cycle after a read has loaded nonzero dout -> dout drops to 0 without a clock edge; array contents preserved (a later read of the same word returns its old value).
2. After reset release, read ADDR 0,1,2,3 (cs=1, WR_RD=1, one per cycle) -> dout = 0x00000000 each, one cycle after each address.
3. Write ADDR 0..3 with 0xABCDEFFF, 0x12345678, 0x98765432, 0xAAAA5555 (WR_RD=0, cs=1), then read 0..3 -> dout returns those values in order with 1-cycle latency; dout unchanged during the writes.
4. With cs=0 and WR_RD=0, drive ADDR=1, din=0xDEADBEEF for several cycles -> mem[1] stays 0x12345678 and dout holds its last value.
5. Write ADDR=0x400 (out of range) din=0x11111111, then read ADDR=0x400 and ADDR=0 -> out-of-range read gives 0; mem[0] still 0xABCDEFFF.
6. With DATAMEM_ASYNC_READ_EN defined, repeat scenario 3 -> dout changes in the same cycle as ADDR; with cs=0, dout = 0.
